// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
//   Shared constants for the MEM stage: reset / write-enable polarities,
//   RISC-V load/store funct3 encodings, FSM state encoding, the writeback
//   record, and the store-side lane helpers (byte enables, data replication,
//   alignment check).
// ---------------------------------------------------------------------------
package mem_access_pkg;

    // Polarities
    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;

    // Load/store width encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stage FSM
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    // Registered MEM/WB result
    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } wb_t;

    // Unsupported encodings are reported as misaligned so they trap the
    // same way instead of silently doing something odd.
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lane enables for an access of the given width at address lo.
    function automatic logic [3:0] store_sel(input logic [2:0] funct3,
                                             input logic [1:0] lo);
        logic [3:0] sel;
        case (funct3)
            F3_B, F3_BU: sel = 4'b0001 << lo;
            F3_H, F3_HU: sel = 4'b0011 << lo;
            F3_W:        sel = 4'b1111;
            default:     sel = 4'b0000;
        endcase
        return sel;
    endfunction

    // Right-aligned store data spread across lanes; the RAM picks the
    // correct copy through the byte enables, so no shift is needed.
    function automatic logic [31:0] store_data(input logic [2:0]  funct3,
                                               input logic [31:0] wdata);
        logic [31:0] d;
        case (funct3)
            F3_B, F3_BU: d = {4{wdata[7:0]}};
            F3_H, F3_HU: d = {2{wdata[15:0]}};
            default:     d = wdata;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Purely combinational load lane extraction and sign/zero extension.
//   Ports:
//     word   in  32  raw RAM read word
//     lane   in  2   byte address bits [1:0]
//     funct3 in  3   load width/sign encoding
//     data   out 32  extended, right-aligned load result
// ---------------------------------------------------------------------------
module load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // Bring the addressed lane down to bit 0; halfword alignment is
        // already guaranteed for H/HU so lane[0] is 0 there.
        shifted = word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = shifted[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   data = {24'h0, byte_v};
            F3_H:    data = {{16{half_v[15]}}, half_v};
            F3_HU:   data = {16'h0, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access
//   Single-issue MEM pipeline stage. Accepts one EX/MEM request per cycle,
//   drives a combinational-read / synchronous-write data RAM, and registers
//   the writeback result one cycle later behind a valid/ready handshake.
//   Misaligned or unsupported accesses raise a sticky trap that blocks the
//   stage until flush_i.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     ex_valid_i / ex_ready_o     EX/MEM handshake
//     ex_mem_en_i, ex_mem_wr_i    memory op / store select
//     ex_funct3_i                 access width and sign
//     ex_addr_i, ex_wdata_i       byte address (or ALU result), store data
//     ex_rd_i, ex_rd_we_i         destination register and enable
//     flush_i                     kill in-flight request and pending result
//     ram_we_o, ram_sel_o         RAM write enable and byte lanes
//     ram_addr_o, ram_data_o      RAM byte address and lane-aligned data
//     ram_data_i                  RAM read word (combinational)
//     wb_valid_o / wb_ready_i     MEM/WB handshake
//     wb_rd_o, wb_we_o, wb_data_o writeback payload
//     exc_o, exc_addr_o           misaligned trap flag and faulting address
// ---------------------------------------------------------------------------
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DataMemNumLog2 = 10
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      ex_valid_i,
    output logic                      ex_ready_o,
    input  logic                      ex_mem_en_i,
    input  logic                      ex_mem_wr_i,
    input  logic [2:0]                ex_funct3_i,
    input  logic [31:0]               ex_addr_i,
    input  logic [31:0]               ex_wdata_i,
    input  logic [4:0]                ex_rd_i,
    input  logic                      ex_rd_we_i,
    input  logic                      flush_i,

    output logic                      ram_we_o,
    output logic [3:0]                ram_sel_o,
    output logic [DataMemNumLog2+1:0] ram_addr_o,
    output logic [31:0]               ram_data_o,
    input  logic [31:0]               ram_data_i,

    output logic                      wb_valid_o,
    input  logic                      wb_ready_i,
    output logic [4:0]                wb_rd_o,
    output logic                      wb_we_o,
    output logic [31:0]               wb_data_o,

    output logic                      exc_o,
    output logic [31:0]               exc_addr_o
);

    logic [0:0]  state;
    wb_t         wb_q;
    wb_t         wb_d;
    logic        accept;
    logic        misaligned;
    logic        good_mem;
    logic [31:0] load_data;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    // Reset is folded in so a request held across reset is never taken.
    assign ex_ready_o = (rst != RstEnable) && (state == ST_RUN)
                        && (!wb_q.valid || wb_ready_i);
    assign accept     = ex_valid_i && ex_ready_o && !flush_i;

    // Alignment only matters for real memory ops; ALU pass-through is free.
    assign misaligned = ex_mem_en_i && is_misaligned(ex_funct3_i, ex_addr_i[1:0]);
    assign good_mem   = accept && ex_mem_en_i && !misaligned;

    // ------------------------------------------------------------------
    // RAM side (combinational in the accept cycle)
    // ------------------------------------------------------------------
    assign ram_addr_o = ex_addr_i[DataMemNumLog2+1:0];
    assign ram_we_o   = (good_mem && ex_mem_wr_i) ? WriteEnable : ~WriteEnable;
    assign ram_sel_o  = good_mem ? store_sel(ex_funct3_i, ex_addr_i[1:0]) : 4'b0000;
    assign ram_data_o = store_data(ex_funct3_i, ex_wdata_i);

    load_align u_load_align (
        .word   (ram_data_i),
        .lane   (ex_addr_i[1:0]),
        .funct3 (ex_funct3_i),
        .data   (load_data)
    );

    // ------------------------------------------------------------------
    // Next writeback payload
    // ------------------------------------------------------------------
    always_comb begin
        wb_d       = '0;
        wb_d.valid = 1'b1;
        wb_d.rd    = ex_rd_i;
        if (!ex_mem_en_i) begin
            wb_d.we   = ex_rd_we_i;
            wb_d.data = ex_addr_i;
        end else if (ex_mem_wr_i) begin
            // Stores complete through MEM/WB but never write the regfile.
            wb_d.we   = 1'b0;
            wb_d.data = 32'h0;
        end else begin
            wb_d.we   = ex_rd_we_i;
            wb_d.data = load_data;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            wb_q <= '0;
        end else if (flush_i) begin
            wb_q.valid <= 1'b0;
        end else if (accept) begin
            // Accept implies any older result was just handed off, so a
            // trapping request simply leaves the slot empty.
            if (misaligned) begin
                wb_q.valid <= 1'b0;
            end else begin
                wb_q <= wb_d;
            end
        end else if (wb_ready_i) begin
            wb_q.valid <= 1'b0;
        end
    end

    assign wb_valid_o = wb_q.valid;
    assign wb_rd_o    = wb_q.rd;
    assign wb_we_o    = wb_q.we;
    assign wb_data_o  = wb_q.data;

    // ------------------------------------------------------------------
    // Trap FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state      <= ST_RUN;
            exc_o      <= 1'b0;
            exc_addr_o <= 32'h0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept && misaligned) begin
                        state      <= ST_TRAP;
                        exc_o      <= 1'b1;
                        exc_addr_o <= ex_addr_i;
                    end
                end
                ST_TRAP: begin
                    // Faulting address is left in place for the handler.
                    if (flush_i) begin
                        state <= ST_RUN;
                        exc_o <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    exc_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access
//   Directed-vector bench for mem_access with a behavioural byte-enabled RAM.
// ---------------------------------------------------------------------------
module tb_mem_access;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i, ex_ready_o, ex_mem_en_i, ex_mem_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_addr_i, ex_wdata_i;
    logic [4:0]  ex_rd_i;
    logic        ex_rd_we_i, flush_i;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0] ram_data_o, ram_data_i;
    logic        wb_valid_o, wb_ready_i, wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        exc_o;
    logic [31:0] exc_addr_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access #(.DataMemNumLog2(10)) dut (
        .clk(clk), .rst(rst),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_mem_en_i(ex_mem_en_i), .ex_mem_wr_i(ex_mem_wr_i),
        .ex_funct3_i(ex_funct3_i), .ex_addr_i(ex_addr_i),
        .ex_wdata_i(ex_wdata_i), .ex_rd_i(ex_rd_i), .ex_rd_we_i(ex_rd_we_i),
        .flush_i(flush_i),
        .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o), .ram_addr_o(ram_addr_o),
        .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
        .exc_o(exc_o), .exc_addr_o(exc_addr_o)
    );

    always #5 clk = ~clk;

    // Behavioural data RAM: combinational read, byte-enabled write.
    logic [31:0] mem [0:1023];
    assign ram_data_i = mem[ram_addr_o[AW-1:2]];
    always @(posedge clk) begin
        if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_sel_o[b]) mem[ram_addr_o[AW-1:2]][b*8 +: 8] <= ram_data_o[b*8 +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mem_en, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic rd_we);
        ex_valid_i  = 1'b1;
        ex_mem_en_i = mem_en;
        ex_mem_wr_i = wr;
        ex_funct3_i = f3;
        ex_addr_i   = addr;
        ex_wdata_i  = wdata;
        ex_rd_i     = rd;
        ex_rd_we_i  = rd_we;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        ex_valid_i = 1'b0;
    endtask

    // Issue a load, return the registered result one cycle later.
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd6, 1'b1);
        tick();
        check({tag, "_data"}, wb_data_o, exp);
        check({tag, "_valid"}, 32'(wb_valid_o), 32'd1);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b1;
        // A store held during reset must not reach the RAM.
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h12345678, 5'd0, 1'b0);
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we_o), 32'd0);
        check("rst_ready", 32'(ex_ready_o), 32'd0);
        tick();
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'h0);
        check("rst_exc", 32'(exc_o), 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // SW 0x10
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
        @(negedge clk);
        check("sw_ready", 32'(ex_ready_o), 32'd1);
        check("sw_we", 32'(ram_we_o), 32'd1);
        check("sw_sel", 32'(ram_sel_o), 32'hF);
        check("sw_wdata", ram_data_o, 32'hDEADBEEF);
        check("sw_addr", 32'(ram_addr_o), 32'h10);
        tick();
        check("sw_wb_valid", 32'(wb_valid_o), 32'd1);
        check("sw_wb_we", 32'(wb_we_o), 32'd0);

        // LW 0x10
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        check("lw_no_we", 32'(ram_we_o), 32'd0);
        tick();
        check("lw_data", wb_data_o, 32'hDEADBEEF);
        check("lw_rd", 32'(wb_rd_o), 32'd5);
        check("lw_we", 32'(wb_we_o), 32'd1);

        // SB 0x13 -> word becomes 0x80ADBEEF
        drive(1'b1, 1'b1, 3'b000, 32'h13, 32'h00000080, 5'd0, 1'b0);
        @(negedge clk);
        check("sb_we", 32'(ram_we_o), 32'd1);
        check("sb_sel", 32'(ram_sel_o), 32'h8);
        check("sb_wdata", ram_data_o, 32'h80808080);
        tick();
        load("lb", 3'b000, 32'h13, 32'hFFFFFF80);
        load("lbu", 3'b100, 32'h13, 32'h00000080);
        load("lh", 3'b001, 32'h12, 32'hFFFF80AD);
        load("lhu", 3'b101, 32'h10, 32'h0000BEEF);

        // SH 0x22
        drive(1'b1, 1'b1, 3'b001, 32'h22, 32'h00001234, 5'd0, 1'b0);
        @(negedge clk);
        check("sh_sel", 32'(ram_sel_o), 32'hC);
        check("sh_wdata", ram_data_o, 32'h12341234);
        tick();
        load("lhu_22", 3'b101, 32'h22, 32'h00001234);

        // ALU pass-through
        drive(1'b0, 1'b0, 3'b000, 32'h12345678, 32'hFFFFFFFF, 5'd3, 1'b1);
        @(negedge clk);
        check("alu_no_we", 32'(ram_we_o), 32'd0);
        tick();
        check("alu_data", wb_data_o, 32'h12345678);
        check("alu_rd", 32'(wb_rd_o), 32'd3);
        check("alu_we", 32'(wb_we_o), 32'd1);

        // Misaligned LH 0x21 -> trap
        drive(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 5'd7, 1'b1);
        @(negedge clk);
        check("mis_no_we", 32'(ram_we_o), 32'd0);
        tick();
        check("mis_exc", 32'(exc_o), 32'd1);
        check("mis_exc_addr", exc_addr_o, 32'h21);
        check("mis_wb_valid", 32'(wb_valid_o), 32'd0);
        drive(1'b1, 1'b1, 3'b010, 32'h30, 32'hFFFFFFFF, 5'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("trap_ready", 32'(ex_ready_o), 32'd0);
            check("trap_no_we", 32'(ram_we_o), 32'd0);
            tick();
            check("trap_exc_hold", 32'(exc_o), 32'd1);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        idle();
        check("flush_exc_clr", 32'(exc_o), 32'd0);
        check("flush_ready", 32'(ex_ready_o), 32'd1);
        drive(1'b0, 1'b0, 3'b000, 32'h55, 32'h0, 5'd4, 1'b1);
        tick();
        check("post_trap_data", wb_data_o, 32'h55);
        check("post_trap_valid", 32'(wb_valid_o), 32'd1);

        // Unsupported funct3 traps like a misaligned access
        drive(1'b1, 1'b0, 3'b011, 32'h40, 32'h0, 5'd8, 1'b1);
        tick();
        check("f3_exc", 32'(exc_o), 32'd1);
        check("f3_exc_addr", exc_addr_o, 32'h40);
        idle();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("f3_exc_clr", 32'(exc_o), 32'd0);

        // Backpressure then back-to-back
        wb_ready_i = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 32'hA1, 32'h0, 5'd1, 1'b1);
        tick();
        check("bp_valid", 32'(wb_valid_o), 32'd1);
        drive(1'b0, 1'b0, 3'b000, 32'hB2, 32'h0, 5'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", 32'(ex_ready_o), 32'd0);
            tick();
            check("bp_hold_data", wb_data_o, 32'hA1);
            check("bp_hold_rd", 32'(wb_rd_o), 32'd1);
            check("bp_hold_valid", 32'(wb_valid_o), 32'd1);
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        check("hs_ready", 32'(ex_ready_o), 32'd1);
        tick();
        check("b2b_data0", wb_data_o, 32'hB2);
        check("b2b_valid0", 32'(wb_valid_o), 32'd1);
        drive(1'b0, 1'b0, 3'b000, 32'hC3, 32'h0, 5'd3, 1'b1);
        tick();
        check("b2b_data1", wb_data_o, 32'hC3);
        check("b2b_valid1", 32'(wb_valid_o), 32'd1);
        idle();
        tick();
        check("drain_valid", 32'(wb_valid_o), 32'd0);

        // SW with flush is dropped
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h11111111, 5'd0, 1'b0);
        flush_i = 1'b1;
        @(negedge clk);
        check("flush_sw_we", 32'(ram_we_o), 32'd0);
        tick();
        flush_i = 1'b0;
        check("flush_sw_valid", 32'(wb_valid_o), 32'd0);
        load("flush_rb", 3'b010, 32'h10, 32'h80ADBEEF);

        // Reset mid-handshake
        wb_ready_i = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 1'b1);
        tick();
        check("pre_rst_valid", 32'(wb_valid_o), 32'd1);
        rst = 1'b1;
        drive(1'b1, 1'b1, 3'b010, 32'h10, 32'h0, 5'd9, 1'b0);
        @(negedge clk);
        check("rst2_ram_we", 32'(ram_we_o), 32'd0);
        check("rst2_ready", 32'(ex_ready_o), 32'd0);
        tick();
        rst = 1'b0;
        idle();
        check("rst2_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst2_wb_rd", 32'(wb_rd_o), 32'd0);
        check("rst2_wb_we", 32'(wb_we_o), 32'd0);
        check("rst2_wb_data", wb_data_o, 32'h0);
        check("rst2_exc", 32'(exc_o), 32'd0);
        check("rst2_exc_addr", exc_addr_o, 32'h0);
        wb_ready_i = 1'b1;
        load("rst2_rb", 3'b010, 32'h10, 32'h80ADBEEF);

        idle();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DataMemNumLog2, default 10: log2 of data RAM word count; byte address width is DataMemNumLog2+2.
REQ-002 clk  in  1  single clock; every register updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high (RstEnable = 1).
REQ-004 ex_valid_i  in  1  EX/MEM request valid.
REQ-005 ex_ready_o  out  1  stage accepts a request this cycle.
REQ-006 ex_mem_en_i  in  1  1 = load/store; 0 = ALU result pass-through.
REQ-007 ex_mem_wr_i  in  1  1 = store, 0 = load.
REQ-008 ex_funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 ex_addr_i  in  32  byte address, or the ALU result when not a memory op.
REQ-010 ex_wdata_i  in  32  store data, right-aligned.
REQ-011 ex_rd_i / ex_rd_we_i  in  5 / 1  destination register and its write enable.
REQ-012 flush_i  in  1  kill the in-flight request and any pending output.
REQ-013 ram_we_o  out  1  RAM write enable (WriteEnable = 1).
REQ-014 ram_sel_o  out  4  byte lane enables.
REQ-015 ram_addr_o  out  DataMemNumLog2+2  RAM byte address.
REQ-016 ram_data_o  out  32  lane-aligned store data.
REQ-017 ram_data_i  in  32  combinational RAM read word.
REQ-018 wb_valid_o / wb_ready_i  out / in  1 / 1  MEM/WB handshake.
REQ-019 wb_rd_o, wb_we_o, wb_data_o  out  5, 1, 32  writeback register, enable and data.
REQ-020 exc_o / exc_addr_o  out  1 / 32  misaligned-access trap flag and faulting address.

Function
REQ-021 ex_ready_o SHALL equal (state==RUN) && (!wb_valid_o || wb_ready_i).
REQ-022 Accept SHALL mean ex_valid_i && ex_ready_o && !flush_i.
REQ-023 An access is misaligned when H/HU has addr[0]=1, or W has addr[1:0]!=0.
REQ-024 ram_addr_o SHALL equal ex_addr_i[DataMemNumLog2+1:0] every cycle.
REQ-025 ram_we_o SHALL be 1 only in an accept cycle of an aligned store, and is combinational in that cycle.
REQ-026 Store byte enables: sel = 0001<<addr[1:0]; half: sel = 0011<<addr[1:0]; word: sel = 1111.
REQ-027 Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-028 Load data SHALL be extracted from ram_data_i in the accept cycle, using the lane selected by addr[1:0].
REQ-029 Load extension: B and H sign-extend; BU and HU zero-extend.
REQ-030 Latency: wb_* SHALL register the result one cycle after accept.
REQ-031 wb_* SHALL hold stable while wb_valid_o && !wb_ready_i.
REQ-032 wb_valid_o SHALL clear after handshake unless a new accept occurs in the same cycle.
REQ-033 Non-memory requests SHALL pass ex_addr_i to wb_data_o unchanged.
REQ-034 Store results SHALL set wb_we_o=0.
REQ-035 On a misaligned accept: no RAM write; wb_valid_o=0; exc_o=1 and exc_addr_o=ex_addr_i next cycle; state RUN->TRAP.
REQ-036 TRAP SHALL hold exc_o=1 and ex_ready_o=0 until flush_i; on flush_i, state returns to RUN and exc_o clears next cycle.
REQ-037 flush_i SHALL suppress ram_we_o in the same cycle and clear wb_valid_o next cycle.
REQ-038 flush_i together with ex_valid_i: flush wins and the request is dropped.
REQ-039 Unsupported funct3 (011, 110, 111) SHALL be handled as misaligned.

Reset
REQ-040 While rst=1: state=RUN; wb_valid_o=0; wb_we_o=0; wb_rd_o=0; wb_data_o=0; exc_o=0; exc_addr_o=0.
REQ-041 While rst=1, ram_we_o and ex_ready_o SHALL be 0, and any request is discarded, including one mid-handshake.

Structure
REQ-042 The funct3 encodings, state encoding, RstEnable and WriteEnable SHALL live in the shared define file.
REQ-043 Load lane extraction and extension SHALL be one sub-module, load_align, which is purely combinational.

Verification
REQ-044 Scenario: SW addr 0x10 data 0xDEADBEEF -> ram_we_o=1, sel=1111; then LW 0x10 -> wb_data_o=0xDEADBEEF one cycle later.
REQ-045 Scenario: SB addr 0x13 data 0x80 -> sel=1000, ram_data_o=0x80808080; then LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080.
REQ-046 Scenario: LH addr 0x21 -> no write, exc_o=1, exc_addr_o=0x21, ex_ready_o=0 until flush_i; after flush, exc_o=0 and a new request is accepted.
REQ-047 Scenario: wb_ready_i=0 for 3 cycles with wb_valid_o=1 -> wb_* stable and ex_ready_o=0; then one handshake cycle with a new accept -> back-to-back results with no bubble.
REQ-048 Scenario: SW asserted together with flush_i -> ram_we_o=0 and the RAM word is unchanged on readback.
REQ-049 Scenario: rst pulsed while wb_valid_o=1 -> all outputs are 0 the following cycle.
